// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI slave controller, the command RAM and the
// wrapper.
//   state_e    - controller FSM states
//   OP_*       - frame opcodes carried in rx_data[9:8]
//   FRAME_LEN  - MOSI frame length in bits
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int unsigned FRAME_LEN = 10;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// spi_slave_ctrl_if: SPI pin and RAM command signals of the SPI slave controller.
//   ss_n, mosi, miso   - SPI pins (SCK is carried separately as clk)
//   rx_data, rx_valid  - 10-bit command frame to the RAM with a one-cycle strobe
//   tx_data, tx_valid  - read byte returned by the RAM, valid as a level
// Modports: slave = controller side, master = pins/RAM side.
interface spi_slave_ctrl_if
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8
);

  logic                 ss_n;
  logic                 mosi;
  logic                 miso;
  logic [FRAME_LEN-1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  modport slave (
    input  ss_n,
    input  mosi,
    input  tx_data,
    input  tx_valid,
    output miso,
    output rx_data,
    output rx_valid
  );

  modport master (
    output ss_n,
    output mosi,
    output tx_data,
    output tx_valid,
    input  miso,
    input  rx_data,
    input  rx_valid
  );

endinterface

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave protocol controller for the single-port command RAM.
// Deserialises 10-bit MOSI frames (MSB first) into RAM commands and, for read-data
// frames, serialises the returned RAM byte onto MISO (MSB first).
// Ports:
//   clk    - SPI serial clock, all logic on the rising edge
//   rst_n  - synchronous active-low reset
//   bus    - spi_slave_ctrl_if.slave (ss_n, mosi, miso, rx_data, rx_valid,
//            tx_data, tx_valid)
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_slave_ctrl_if.slave    bus
);

  localparam logic [3:0] RxBitsLeft = 4'(FRAME_LEN - 1);
  // Byte bits plus one trailing edge that retires rd_addr_done.
  localparam logic [3:0] TxBitsLeft = 4'(ADDR_SIZE);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [FRAME_LEN-1:0] rx_q, rx_d;
  logic [ADDR_SIZE-1:0] tx_q, tx_d;
  logic                 rd_addr_done_q, rd_addr_done_d;
  logic                 frame_done_q, frame_done_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 miso_q, miso_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rx_q           <= '0;
      tx_q           <= '0;
      rd_addr_done_q <= 1'b0;
      frame_done_q   <= 1'b0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rx_q           <= rx_d;
      tx_q           <= tx_d;
      rd_addr_done_q <= rd_addr_done_d;
      frame_done_q   <= frame_done_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rx_d           = rx_q;
    tx_d           = tx_q;
    rd_addr_done_d = rd_addr_done_q;
    frame_done_d   = frame_done_q;
    rx_valid_d     = 1'b0;
    miso_d         = miso_q;

    if (state_q != IDLE && bus.ss_n) begin
      // Abort: drop any partial frame, keep rd_addr_done.
      state_d      = IDLE;
      cnt_d        = '0;
      frame_done_d = 1'b0;
      miso_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!bus.ss_n) state_d = CHK_CMD;
        end

        CHK_CMD: begin
          rx_d  = {rx_q[FRAME_LEN-2:0], bus.mosi};
          cnt_d = RxBitsLeft;
          if (!bus.mosi)          state_d = WRITE;
          else if (rd_addr_done_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (!frame_done_q) begin
            rx_d  = {rx_q[FRAME_LEN-2:0], bus.mosi};
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              rx_valid_d   = 1'b1;
              frame_done_d = 1'b1;
              if (state_q == READ_ADD) rd_addr_done_d = 1'b1;
            end
          end else if (state_q == READ_DATA) begin
            if (rx_valid_q) begin
              // Strobe cycle: tx_valid is still stale from the previous command.
            end else if (!rd_addr_done_q) begin
              // Byte already shifted out; hold until ss_n rises.
            end else if (cnt_q == 4'd0) begin
              if (bus.tx_valid) begin
                miso_d = bus.tx_data[ADDR_SIZE-1];
                tx_d   = {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
                cnt_d  = TxBitsLeft;
              end
            end else if (cnt_q == 4'd1) begin
              miso_d         = 1'b0;
              rd_addr_done_d = 1'b0;
              cnt_d          = '0;
            end else begin
              miso_d = tx_q[ADDR_SIZE-1];
              tx_d   = {tx_q[ADDR_SIZE-2:0], 1'b0};
              cnt_d  = cnt_q - 4'd1;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.miso     = miso_q;
  assign bus.rx_data  = rx_q;
  assign bus.rx_valid = rx_valid_q;

endmodule
